// File: rtl/silu_act_arbiter_if.sv
// Lane-side request bus, shared SiLU operand/result pair and tagged response bus
// for the SiLU activation arbiter.
interface silu_act_arbiter_if #(
  parameter int IL   = 4,
  parameter int FL   = 16,
  parameter int NREQ = 4
);
  localparam int W   = IL + FL;
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ*W-1:0]   req_data;
  logic [NREQ-1:0]     req_last;
  logic [NREQ-1:0]     req_ready;
  logic signed [W-1:0] silu_in;
  logic signed [W-1:0] silu_out;
  logic                rsp_valid;
  logic signed [W-1:0] rsp_data;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_last;
  logic                rsp_ready;
  logic                busy;

  modport master (
    output req_valid, req_data, req_last, silu_out, rsp_ready,
    input  req_ready, silu_in, rsp_valid, rsp_data, rsp_id, rsp_last, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, silu_out, rsp_ready,
    output req_ready, silu_in, rsp_valid, rsp_data, rsp_id, rsp_last, busy
  );
endinterface

// File: rtl/silu_act_arbiter.sv
// Burst-locked round-robin arbiter sharing one combinational SiLU unit among NREQ lanes;
// each accepted beat's result is registered and tagged with its lane id.
module silu_act_arbiter #(
  parameter int IL       = 4,
  parameter int FL       = 16,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  silu_act_arbiter_if.slave bus
);
  localparam int W   = IL + FL;
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(MAXBURST + 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              r_state;
  logic [IDW-1:0]      r_grant;
  logic [IDW-1:0]      r_rr_ptr;
  logic [CW-1:0]       r_beat_cnt;
  logic                r_rsp_vld_p0;
  logic signed [W-1:0] r_rsp_data_p0;
  logic [IDW-1:0]      r_rsp_id_p0;
  logic                r_rsp_last_p0;

  logic [IDW-1:0]      w_pick;
  logic                w_found;
  logic                w_streaming;
  logic                w_slot_free;
  logic                w_accept;
  logic                w_release;
  logic [CW-1:0]       w_cnt_next;
  logic signed [W-1:0] w_lane_data;

  // Search starts one past the last released lane so it is served last.
  always_comb begin
    int c;
    w_pick  = r_rr_ptr;
    w_found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      c = (int'(r_rr_ptr) + i) % NREQ;
      if (!w_found && bus.req_valid[c]) begin
        w_pick  = IDW'(c);
        w_found = 1'b1;
      end
    end
  end

  assign w_streaming = (r_state == STREAM);
  assign w_slot_free = !r_rsp_vld_p0 || bus.rsp_ready;
  assign w_lane_data = bus.req_data[int'(r_grant)*W +: W];
  assign w_accept    = w_streaming && w_slot_free && bus.req_valid[r_grant];
  assign w_cnt_next  = r_beat_cnt + 1'b1;
  assign w_release   = bus.req_last[r_grant] || (w_cnt_next == CW'(MAXBURST));

  always_comb begin
    bus.req_ready = '0;
    if (w_streaming && w_slot_free) bus.req_ready[r_grant] = 1'b1;
  end

  assign bus.silu_in   = w_streaming ? w_lane_data : '0;
  assign bus.rsp_valid = r_rsp_vld_p0;
  assign bus.rsp_data  = r_rsp_data_p0;
  assign bus.rsp_id    = r_rsp_id_p0;
  assign bus.rsp_last  = r_rsp_last_p0;
  assign bus.busy      = i_rst_n && ((r_state != IDLE) || r_rsp_vld_p0 || (|bus.req_valid));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_rr_ptr      <= IDW'(NREQ - 1);
      r_beat_cnt    <= '0;
      r_rsp_vld_p0  <= 1'b0;
      r_rsp_data_p0 <= '0;
      r_rsp_id_p0   <= '0;
      r_rsp_last_p0 <= 1'b0;
    end else begin
      // p0: output register drains unless refilled by this cycle's accept
      if (r_rsp_vld_p0 && bus.rsp_ready && !w_accept) r_rsp_vld_p0 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant    <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= STREAM;
          end
        end
        STREAM: begin
          if (w_accept) begin
            r_rsp_vld_p0  <= 1'b1;
            r_rsp_data_p0 <= bus.silu_out;
            r_rsp_id_p0   <= r_grant;
            r_rsp_last_p0 <= bus.req_last[r_grant];
            r_beat_cnt    <= w_cnt_next;
            if (w_release) begin
              r_rr_ptr <= r_grant;
              r_state  <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_silu_act_arbiter.sv
// Bench for silu_act_arbiter: per-lane beat queues drive the lanes, and a transaction-level
// round-robin model predicts the tagged response stream (silu_out stubbed as ~silu_in).
module tb_silu_act_arbiter;
  localparam int IL = 4, FL = 16, NREQ = 4, MAXBURST = 16;
  localparam int W = IL + FL, IDW = $clog2(NREQ);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  silu_act_arbiter_if #(.IL(IL), .FL(FL), .NREQ(NREQ)) bus();
  assign bus.silu_out = ~bus.silu_in;

  silu_act_arbiter #(.IL(IL), .FL(FL), .NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_tests = 0, n_fail = 0;
  logic [W:0]     lane_q [NREQ][$];
  logic [IDW+W:0] exp_q [$];
  bit gap_mode, bp_mode, tim_mode, in_prog, last_end, first_seen;
  int stall_from, stall_len, step_no, gap_cnt, cur, bcnt, last_acc;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-burst view: next nonempty lane after the last released one, up to its last
  // beat or MAXBURST beats. A lane that runs dry mid-burst keeps the unit forever.
  task automatic build_expected();
    int ptr, lane;
    int rd [NREQ];
    bit stuck;
    logic [W:0] beat;
    ptr = NREQ - 1;
    stuck = 0;
    exp_q.delete();
    for (int k = 0; k < NREQ; k++) rd[k] = 0;
    while (!stuck) begin
      lane = -1;
      for (int i = 1; i <= NREQ; i++)
        if (lane < 0 && rd[(ptr + i) % NREQ] < lane_q[(ptr + i) % NREQ].size()) lane = (ptr + i) % NREQ;
      if (lane < 0) break;
      for (int n = 1; n <= MAXBURST; n++) begin
        if (rd[lane] >= lane_q[lane].size()) begin stuck = 1; break; end
        beat = lane_q[lane][rd[lane]];
        rd[lane]++;
        exp_q.push_back({IDW'(lane), ~beat[W-1:0], beat[W]});
        if (beat[W]) break;
      end
      ptr = lane;
    end
  endtask

  task automatic prepare(bit gm, bit bm, bit tm, int sf, int sl);
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < NREQ; k++) lane_q[k].delete();
    gap_mode = gm; bp_mode = bm; tim_mode = tm; stall_from = sf; stall_len = sl;
    step_no = 0; gap_cnt = 0; cur = 0; bcnt = 0; last_acc = 0;
    in_prog = 0; last_end = 0; first_seen = 0;
    @(negedge clk);
  endtask

  task automatic push_burst(int lane, int len, bit with_last, bit rnd, int base);
    logic [W-1:0] d;
    for (int i = 0; i < len; i++) begin
      d = rnd ? W'($urandom) : W'(base * (i + 1));
      lane_q[lane].push_back({with_last && (i == len - 1), d});
    end
  endtask

  task automatic step();
    logic [NREQ-1:0] rdy;
    logic [IDW+W:0] e, held;
    logic [W:0] beat;
    bit hold, gap_on, ends, v;
    int acc;
    @(negedge clk);
    if (gap_mode && in_prog && gap_cnt == 0 && $urandom_range(3) == 0) gap_cnt = 3;
    gap_on = in_prog && gap_cnt > 0;
    if (gap_cnt > 0) gap_cnt--;
    if (step_no >= stall_from && step_no < stall_from + stall_len) bus.rsp_ready = 1'b0;
    else bus.rsp_ready = bp_mode ? 1'($urandom_range(2) != 0) : 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      v = (lane_q[k].size() != 0) && !(gap_on && k == cur);
      bus.req_valid[k] = v;
      bus.req_last[k]  = v ? lane_q[k][0][W] : 1'($urandom_range(1));
      bus.req_data[k*W +: W] = v ? lane_q[k][0][W-1:0] : W'($urandom);
    end
    #1;
    rdy = bus.req_ready;
    chk("req_ready_onehot", 64'($onehot0(rdy)), 1);
    if (in_prog) chk("req_ready_other_lane", 64'(rdy & ~(NREQ'(1) << cur)), 0);
    if (in_prog || bus.rsp_valid) chk("busy", 64'(bus.busy), 1);
    hold = bus.rsp_valid && !bus.rsp_ready;
    held = {bus.rsp_id, bus.rsp_data, bus.rsp_last};
    if (hold) chk("req_ready_backpressure", 64'(rdy), 0);
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 64'(bus.rsp_valid), 0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_id", 64'(bus.rsp_id), 64'(e[IDW+W:W+1]));
        chk("rsp_data", 64'($unsigned(bus.rsp_data)), 64'(e[W:1]));
        chk("rsp_last", 64'(bus.rsp_last), 64'(e[0]));
      end
    end
    acc = -1;
    for (int k = 0; k < NREQ; k++) if (bus.req_valid[k] && rdy[k]) acc = k;
    if (acc >= 0) begin
      beat = lane_q[acc].pop_front();
      chk("silu_in", 64'($unsigned(bus.silu_in)), 64'(beat[W-1:0]));
      if (tim_mode) begin
        if (!first_seen) chk("first_beat_step", step_no, 1);
        else chk("beat_spacing", step_no - last_acc, last_end ? 2 : 1);
      end
      if (!in_prog) begin cur = acc; bcnt = 0; end
      bcnt++;
      ends = beat[W] || (bcnt == MAXBURST);
      in_prog = !ends; last_end = ends; last_acc = step_no; first_seen = 1;
      if (ends) gap_cnt = 0;
    end
    @(posedge clk);
    #1;
    if (hold) begin
      chk("hold_valid", 64'(bus.rsp_valid), 1);
      chk("hold_payload", 64'({bus.rsp_id, bus.rsp_data, bus.rsp_last}), 64'(held));
    end
    step_no++;
  endtask

  task automatic run(int budget);
    build_expected();
    rst_n = 1'b1;
    while (exp_q.size() != 0 && step_no < budget) step();
    chk("all_responses_seen", exp_q.size(), 0);
    repeat (4) step();
  endtask

  initial begin
    // Reset mid-stream while a result is held by backpressure.
    prepare(0, 0, 0, 0, 1000);
    push_burst(2, 3, 1, 0, 16);
    build_expected();
    rst_n = 1'b1;
    repeat (3) step();
    chk("pre_reset_rsp_valid", 64'(bus.rsp_valid), 1);
    chk("pre_reset_rsp_id", 64'(bus.rsp_id), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 0);
    chk("reset_rsp_data", 64'($unsigned(bus.rsp_data)), 0);
    chk("reset_rsp_id", 64'(bus.rsp_id), 0);
    chk("reset_rsp_last", 64'(bus.rsp_last), 0);
    chk("reset_req_ready", 64'(bus.req_ready), 0);
    chk("reset_busy", 64'(bus.busy), 0);
    chk("reset_silu_in", 64'($unsigned(bus.silu_in)), 0);

    // Single lane 2, three beats 0x10,0x20,0x30 with last on the third.
    prepare(0, 0, 1, 0, 0);
    push_burst(2, 3, 1, 0, 16);
    run(200);

    // All lanes one-beat bursts, lane 0 twice: order 0,1,2,3,0.
    prepare(0, 0, 1, 0, 0);
    for (int k = 0; k < NREQ; k++) push_burst(k, 1, 1, 1, 0);
    push_burst(0, 1, 1, 1, 0);
    run(200);

    // Lane 1 twenty beats without last: forced release after 16.
    prepare(0, 0, 1, 0, 0);
    push_burst(1, 20, 0, 1, 0);
    push_burst(2, 1, 1, 1, 0);
    push_burst(3, 1, 1, 1, 0);
    push_burst(0, 1, 1, 1, 0);
    run(300);

    // Five-cycle downstream stall with a result pending.
    prepare(0, 0, 0, 3, 5);
    push_burst(3, 6, 1, 1, 0);
    push_burst(0, 4, 1, 1, 0);
    run(300);

    // Granted lane drops valid mid-burst.
    prepare(1, 0, 0, 0, 0);
    push_burst(0, 8, 1, 1, 0);
    push_burst(2, 8, 1, 1, 0);
    push_burst(0, 5, 1, 1, 0);
    run(500);

    // Random bursts with valid gaps and random backpressure.
    for (int r = 0; r < 3; r++) begin
      prepare(1, 1, 0, 0, 0);
      for (int k = 0; k < NREQ; k++)
        for (int b = 0; b < int'($urandom_range(3)); b++)
          push_burst(k, int'($urandom_range(20, 1)), 1, 1, 0);
      run(3000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end
endmodule
